// File: rtl/ps2_host_tx_if.sv
// Command-side handshake bundle for the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       rx_inhibit;
  logic       done;
  logic       ack_ok;
  logic       err_nack;
  logic       err_timeout;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_inhibit, done, ack_ok, err_nack, err_timeout
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_inhibit, done, ack_ok, err_nack, err_timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked
// shift of start/data/parity/stop, then ACK sampling on the 11th clock.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  tx,
  input  logic          kb_clk_in,
  input  logic          kb_data_in,
  output logic          kb_clk_drive_low,
  output logic          kb_data_drive_low
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FLT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  // data is pulled low one cycle before the clock is released
  localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'((INHIBIT_CYCLES >= 2) ? INHIBIT_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] TMO_VAL  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
  localparam logic             INH_ONE  = (INHIBIT_CYCLES < 2);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE
  } state_t;

  // synchroniser + glitch filter
  logic             clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic             dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic             flt_q, flt_d;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic             fall;

  // transfer state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             tmo_hit;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [8:0]       sh_q, sh_d;
  logic             clk_drv_q, clk_drv_d, dat_drv_q, dat_drv_d;
  logic             rdy_q, rdy_d, inh_q, inh_d, done_q, done_d;
  logic             ack_q, ack_d, nack_q, nack_d, tmo_q, tmo_d;

  // filtered kb_clk flips only after FILTER_LEN consecutive samples of the new level
  always_comb begin
    clk_s1_d  = kb_clk_in;
    clk_s2_d  = clk_s1_q;
    dat_s1_d  = kb_data_in;
    dat_s2_d  = dat_s1_q;
    flt_d     = flt_q;
    flt_cnt_d = '0;
    if (clk_s2_q != flt_q) begin
      if (flt_cnt_q == FLT_LAST) flt_d = clk_s2_q;
      else                       flt_cnt_d = flt_cnt_q + 1'b1;
    end
  end

  assign fall = flt_q & ~flt_d;

  // next-state and output computation for the transfer sequencer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    clk_drv_d = clk_drv_q;
    dat_drv_d = dat_drv_q;
    rdy_d     = rdy_q;
    inh_d     = inh_q;
    done_d    = 1'b0;
    ack_d     = ack_q;
    nack_d    = nack_q;
    tmo_d     = tmo_q;
    cnt_inc   = cnt_q + 1'b1;
    tmo_hit   = (cnt_inc == TMO_VAL);
    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (tx.tx_valid && rdy_q) begin
          sh_d      = {~^tx.tx_data, tx.tx_data};
          bit_cnt_d = '0;
          ack_d     = 1'b0;
          nack_d    = 1'b0;
          tmo_d     = 1'b0;
          rdy_d     = 1'b0;
          inh_d     = 1'b1;
          clk_drv_d = 1'b1;
          dat_drv_d = INH_ONE;
          cnt_d     = '0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        cnt_d = cnt_inc;
        if (cnt_q == INH_LAST) begin
          clk_drv_d = 1'b0;
          cnt_d     = '0;
          state_d   = RTS;
        end else if (cnt_q == INH_PRE) begin
          dat_drv_d = 1'b1;
        end
      end
      RTS, SHIFT, ACK: begin
        if (fall) begin
          cnt_d = '0;
          if (state_q == ACK) begin
            ack_d   = ~dat_s2_q;
            nack_d  = dat_s2_q;
            state_d = WAIT_IDLE;
          end else if (bit_cnt_q == 4'd9) begin
            dat_drv_d = 1'b0;              // stop bit: release data
            bit_cnt_d = 4'd10;
            state_d   = ACK;
          end else begin
            dat_drv_d = ~sh_q[0];
            sh_d      = {1'b0, sh_q[8:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = SHIFT;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_IDLE: begin
        cnt_d = cnt_inc;
        if (flt_q && dat_s2_q) begin
          done_d  = 1'b1;
          inh_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // abort: the device stopped clocking; overrides any in-progress decision
    if (state_q inside {RTS, SHIFT, ACK, WAIT_IDLE} && !fall && !done_d && tmo_hit) begin
      clk_drv_d = 1'b0;
      dat_drv_d = 1'b0;
      ack_d     = 1'b0;
      nack_d    = 1'b0;
      tmo_d     = 1'b1;
      done_d    = 1'b1;
      inh_d     = 1'b0;
      state_d   = IDLE;
    end
  end

  // all state and outputs registered; reset releases both lines immediately
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      flt_q     <= 1'b1;
      flt_cnt_q <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      clk_drv_q <= 1'b0;
      dat_drv_q <= 1'b0;
      rdy_q     <= 1'b1;
      inh_q     <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      nack_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      clk_s1_q  <= clk_s1_d;
      clk_s2_q  <= clk_s2_d;
      dat_s1_q  <= dat_s1_d;
      dat_s2_q  <= dat_s2_d;
      flt_q     <= flt_d;
      flt_cnt_q <= flt_cnt_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      clk_drv_q <= clk_drv_d;
      dat_drv_q <= dat_drv_d;
      rdy_q     <= rdy_d;
      inh_q     <= inh_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      nack_q    <= nack_d;
      tmo_q     <= tmo_d;
    end
  end

  assign kb_clk_drive_low  = clk_drv_q;
  assign kb_data_drive_low = dat_drv_q;
  assign tx.tx_ready       = rdy_q;
  assign tx.rx_inhibit     = inh_q;
  assign tx.done           = done_q;
  assign tx.ack_ok         = ack_q;
  assign tx.err_nack       = nack_q;
  assign tx.err_timeout    = tmo_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model, PS/2 device model clocking at
// 12.5 kHz (80 cycles of a 1 MHz clk), and a done-driven scoreboard.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH  = 100;
  localparam int TMO  = 1000;
  localparam int FLT  = 2;
  localparam int HALF = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #500 clk = ~clk;

  ps2_host_tx_if bus();
  logic kb_clk_drive_low, kb_data_drive_low;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic kb_clk_in, kb_data_in;
  assign kb_clk_in  = ~(kb_clk_drive_low | dev_clk_low);
  assign kb_data_in = ~(kb_data_drive_low | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLT)) dut (
    .clk(clk), .rst(rst), .tx(bus),
    .kb_clk_in(kb_clk_in), .kb_data_in(kb_data_in),
    .kb_clk_drive_low(kb_clk_drive_low), .kb_data_drive_low(kb_data_drive_low)
  );

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h @cyc %0d", name, act, req, cyc);
    end
  endtask

  // code: 0 ack, 1 nack, 2 timeout
  typedef struct { logic [7:0] b; logic [1:0] code; logic par; } exp_t;
  exp_t exp_q[$];
  logic [9:0] rx_q[$];

  typedef enum int {M_ACK, M_NACK, M_NOCLK, M_GLITCH} mode_t;
  mode_t mode = M_ACK;
  logic dev_busy = 1'b0;
  int   dev_edge = 0;

  // device: on request-to-send, generate 10 clocks sampling on rising edges, then ACK clock
  initial begin : device
    logic [9:0] bits;
    bits = '0;
    forever begin
      @(negedge clk);
      if (!kb_clk_drive_low && kb_data_drive_low) begin
        dev_busy = 1'b1;
        if (mode == M_NOCLK) begin
          for (int i = 0; i < 3*TMO && kb_data_drive_low; i++) @(negedge clk);
        end else begin
          repeat (20) @(negedge clk);
          for (int k = 1; k <= 10; k++) begin
            dev_edge = k;
            dev_clk_low = 1'b1; repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0; repeat (HALF/2) @(negedge clk);
            if (mode == M_GLITCH && k == 3) begin
              dev_clk_low = 1'b1; @(negedge clk); dev_clk_low = 1'b0;
            end
            bits[k-1] = kb_data_in;
            repeat (HALF/2) @(negedge clk);
          end
          dev_edge = 11;
          dev_data_low = (mode != M_NACK);
          repeat (5) @(negedge clk);
          dev_clk_low = 1'b1; repeat (HALF) @(negedge clk);
          dev_clk_low = 1'b0;
          rx_q.push_back(bits);
          repeat (5) @(negedge clk);
          dev_data_low = 1'b0;
        end
        dev_edge = 0;
        dev_busy = 1'b0;
      end
    end
  end

  // inhibit length, start bit and the both-low window
  int inh_run = 0, rts_cyc = 0, viol_both = 0;
  logic prev_clk_drv = 1'b0;
  initial begin : line_watch
    forever begin
      @(negedge clk);
      if (kb_clk_drive_low) begin
        if (kb_data_drive_low && inh_run != INH-1) viol_both++;
        inh_run++;
      end else begin
        if (prev_clk_drv) begin
          check("inhibit_len", inh_run, INH);
          check("rts_start_bit", kb_data_drive_low, 1'b1);
          rts_cyc = cyc;
        end
        inh_run = 0;
      end
      prev_clk_drv = kb_clk_drive_low;
    end
  end

  // rx_inhibit coverage of the busy window, done/tx_ready exclusion
  logic busy_tb = 1'b0;
  int viol_inh = 0, viol_dr = 0;
  always @(posedge clk) begin
    if (!rst || bus.done) busy_tb = 1'b0;
    else if (bus.tx_valid && bus.tx_ready) busy_tb = 1'b1;
  end
  always @(negedge clk) begin
    if (busy_tb && !bus.rx_inhibit && !bus.done) viol_inh++;
    if (bus.done && bus.tx_ready) viol_dr++;
  end

  // scoreboard monitor: every done pops one expectation
  int done_cnt = 0;
  initial begin : monitor
    exp_t e;
    logic [9:0] f;
    forever begin
      @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("ack_ok", bus.ack_ok, e.code == 2'd0);
          check("err_nack", bus.err_nack, e.code == 2'd1);
          check("err_timeout", bus.err_timeout, e.code == 2'd2);
          check("ready_at_done", bus.tx_ready, 1'b0);
          check("lines_released", {kb_clk_drive_low, kb_data_drive_low}, 2'b00);
          if (e.code == 2'd2) check("timeout_latency", cyc - rts_cyc, TMO);
          else if (rx_q.size() == 0) check("frame_missing", 1, 0);
          else begin
            f = rx_q.pop_front();
            check("frame", f, {1'b1, e.par, e.b});
          end
          @(negedge clk);
          check("ready_after_done", bus.tx_ready, 1'b1);
        end
      end
    end
  end

  // code 3: transfer will be reset away, nothing expected
  task automatic send(input logic [7:0] b, input logic [1:0] code, input logic par, input logic hold);
    int n;
    n = 0;
    while (!bus.tx_ready && n < 5000) begin @(negedge clk); n++; end
    if (!bus.tx_ready) check("ready_wait", 0, 1);
    if (code != 2'd3) exp_q.push_back('{b: b, code: code, par: par});
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) bus.tx_valid = 1'b0;
    bus.tx_data = ~b;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.done && n < 5000);
    if (!bus.done) check("done_wait", 0, 1);
    bus.tx_valid = 1'b0;
    n = 0;
    while ((dev_busy || !bus.tx_ready) && n < 5000) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
  endtask

  initial begin : stim
    int n;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_ready", bus.tx_ready, 1'b1);
    check("rst_outs", {bus.rx_inhibit, bus.done, bus.ack_ok, bus.err_nack, bus.err_timeout,
                       kb_clk_drive_low, kb_data_drive_low}, 7'b0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // 1, 2: good transfers; parity hand-computed
    mode = M_ACK;
    send(8'hED, 2'd0, 1'b1, 1'b0); wait_done();
    send(8'h07, 2'd0, 1'b0, 1'b0); wait_done();
    send(8'h00, 2'd0, 1'b1, 1'b0); wait_done();

    // 3: device never clocks
    mode = M_NOCLK;
    send(8'hF0, 2'd2, 1'b1, 1'b0); wait_done();

    // 4: no ACK from device
    mode = M_NACK;
    send(8'hF4, 2'd1, 1'b0, 1'b0); wait_done();

    // 5: reset while d4 is on the line, then a clean 0xFF
    mode = M_ACK;
    send(8'h5A, 2'd3, 1'b0, 1'b0);
    n = 0;
    while (dev_edge != 5 && n < 5000) begin @(negedge clk); n++; end
    check("reach_d4", dev_edge, 5);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_lines", {kb_clk_drive_low, kb_data_drive_low}, 2'b00);
    check("midrst_ready", bus.tx_ready, 1'b1);
    check("midrst_outs", {bus.rx_inhibit, bus.done, bus.ack_ok, bus.err_nack, bus.err_timeout}, 5'b0);
    rst = 1'b1;
    n = 0;
    while (dev_busy && n < 5000) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    rx_q.delete();
    check("idle_edges_ignored", bus.rx_inhibit, 1'b0);
    send(8'hFF, 2'd0, 1'b1, 1'b0); wait_done();

    // 6: valid held, data changed mid-frame, clock glitch
    mode = M_GLITCH;
    send(8'hAA, 2'd0, 1'b1, 1'b1);
    repeat (400) @(negedge clk);
    bus.tx_data = 8'h55;
    wait_done();
    repeat (300) @(negedge clk);
    check("no_reaccept", bus.rx_inhibit, 1'b0);

    check("done_count", done_cnt, 7);
    check("exp_q_empty", exp_q.size(), 0);
    check("rx_inhibit_gap", viol_inh, 0);
    check("done_with_ready", viol_dr, 0);
    check("both_low_outside", viol_both, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #(90000 * 1000);
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule
